rv32_input_reg: RTL and testbench
=================================

# rv32_input_reg

MMIO read-side peripheral for the PicoRV32 bus: samples board switches and push-buttons, synchronizes and debounces them, and exposes their state plus sticky button-press flags as readable registers. It is the input-direction counterpart to the write-only display registers on the same bus and sits behind the address decoder as one bus slave.

## Interface

- SWITCHES, 16, number of switch inputs (1..32)
- BUTTONS, 4, number of button inputs (1..8)
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a new input level (≥1); counter width $clog2(DEBOUNCE_CYCLES+1)

- clk  in  1  system clock
- rst  in  1  reset; one clock, synchronous, active-high
- rv32_valid  in  1  transaction request; held by master until rv32_ready
- rv32_ready  out  1  one-cycle transaction acknowledge
- rv32_addr  in  4  byte address within slave; bits [3:2] select register
- rv32_wdata  in  32  write data
- rv32_wstrb  in  4  byte write strobes; 0 = read
- rv32_rdata  out  32  read data, valid while rv32_ready=1
- sw_in  in  SWITCHES  raw asynchronous switch levels
- btn_in  in  BUTTONS  raw asynchronous button levels, 1 = pressed

## Operation

- Per input bit: 2-flop synchronizer → debouncer → debounced state bit.
- Debouncer per bit: counter cnt, state st. If sync == st: cnt ← 0. Else if cnt == DEBOUNCE_CYCLES-1: st ← sync, cnt ← 0. Else cnt ← cnt+1. Any single-cycle return to st restarts the count.
- Press latch per button: set on cycle where debounced btn goes 0→1. Release (1→0) does not affect it.
- Register map (rv32_addr[3:2]):
  - 0 SW_STATE: read = debounced switches, zero-extended; writes ignored
  - 1 BTN_STATE: read = debounced buttons, zero-extended; writes ignored
  - 2 BTN_PRESSED: read = press latches, zero-extended; write with rv32_wstrb[0]=1 clears each latch whose rv32_wdata bit is 1 (W1C); wstrb[0]=0 → no effect
  - 3 reserved: reads 0, writes ignored
- rv32_addr[1:0] ignored; no bus errors.
- Set and W1C clear of the same latch in the same cycle: set wins (latch = 1).
- Reset values: rv32_ready 0, rv32_rdata 0, all synchronizer flops, counters, debounced states and latches 0. Input held high through reset is accepted as a 0→1 change after debounce; a button held through reset therefore sets its latch.

## Timing

- Accept: a transaction is accepted on a clk edge where rv32_valid=1 and rv32_ready=0. On that edge rv32_ready ← 1 and rv32_rdata ← selected register value as of that cycle (0 for writes); W1C takes effect on the same edge.
- rv32_ready is high exactly one cycle, then 0; the following cycle cannot accept (valid still high from the completed transaction is not re-accepted). Back-to-back transactions: one per 2 cycles max.
- rv32_rdata holds its value until the next accept.
- Read in the accept cycle of a W1C observes pre-clear latch value only if it is a read; a write returns 0.
- Input latency: raw edge stable from cycle t → sync output changes at t+2 → debounced state changes at edge t+2+DEBOUNCE_CYCLES; latch sets on the same edge.
- Reset asserted mid-transaction: rv32_ready forced 0 next edge, pending transaction dropped; all state returns to reset values.

## Test plan

- Reset: hold rst 2 cycles, all inputs 0 → rv32_ready=0, rv32_rdata=0; reads of addr 0x0/0x4/0x8/0xC return 0x00000000.
- Debounce, DEBOUNCE_CYCLES=4: sw_in[0] 0→1 at cycle 10 and held → SW_STATE bit0 becomes 1 at edge 16, not 15; glitch sw_in[3] high for 3 cycles → SW_STATE stays 0x0.
- Press latch: btn_in=4'b0100 for 10 cycles then 0 → BTN_STATE reads 0x4 then 0x0; BTN_PRESSED reads 0x4 after release; write 0x4 to 0x8 with wstrb=4'b0001 → BTN_PRESSED reads 0x0; write with wstrb=4'b0010 → stays 0x4.
- Set/clear collision: W1C 0x1 to 0x8 accepted on the same edge button 0 debounces to 1 → BTN_PRESSED reads 0x1.
- Handshake: rv32_valid held high 6 cycles, read of 0x0 with SW_STATE=0xA5A5 → rv32_ready pattern 0,1,0,1,0,1 with rv32_rdata=0x0000A5A5 on each ready cycle; write to 0x0 → rdata 0, SW_STATE unchanged.
- Reset mid-operation: assert rst on the accept edge of a read and mid-debounce count → next cycle rv32_ready=0, counters cleared; input change requires full 2+DEBOUNCE_CYCLES after rst release.

Source files
------------

// File: rtl/rv32_input_reg.sv
// rv32_input_reg: PicoRV32 MMIO slave exposing synchronized, debounced switches and
// buttons plus sticky write-one-to-clear button-press flags.
module rv32_input_reg #(
   parameter int SWITCHES = 16,
   parameter int BUTTONS = 4,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                rv32_valid,
   output logic                rv32_ready,
   input  logic [3:0]          rv32_addr,
   input  logic [31:0]         rv32_wdata,
   input  logic [3:0]          rv32_wstrb,
   output logic [31:0]         rv32_rdata,
   input  logic [SWITCHES-1:0] sw_in,
   input  logic [BUTTONS-1:0]  btn_in
);
   localparam int N = SWITCHES + BUTTONS;
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
   logic [N-1:0] s1, s2, st, take;
   logic [CW-1:0] cnt [N];
   logic [BUTTONS-1:0] pressed, rise, clr;
   logic [31:0] sel;
   logic accept, write, unused;
   assign accept = rv32_valid && !rv32_ready;
   assign write = |rv32_wstrb;
   // a button latch sets on the very edge its debounced level flips to 1
   assign rise = take[N-1:SWITCHES] & s2[N-1:SWITCHES];
   assign clr = (accept && rv32_addr[3:2] == 2'd2 && rv32_wstrb[0]) ? rv32_wdata[BUTTONS-1:0] : '0;
   assign unused = ^{rv32_addr[1:0], rv32_wdata, rv32_wstrb[3:1]};
   always_comb begin
      take = '0;
      for (int i = 0; i < N; i++)
         take[i] = s2[i] != st[i] && cnt[i] == LAST;
   end
   always_comb
      sel = rv32_addr[3:2] == 2'd0 ? 32'(st[SWITCHES-1:0]) :
            rv32_addr[3:2] == 2'd1 ? 32'(st[N-1:SWITCHES]) :
            rv32_addr[3:2] == 2'd2 ? 32'(pressed) : '0;
   always_ff @(posedge clk)
      if (rst) begin
         s1 <= '0;
         s2 <= '0;
         st <= '0;
         pressed <= '0;
         rv32_ready <= 1'b0;
         rv32_rdata <= '0;
         for (int i = 0; i < N; i++)
            cnt[i] <= '0;
      end else begin
         s1 <= {btn_in, sw_in};
         s2 <= s1;
         st <= st ^ take;
         for (int i = 0; i < N; i++)
            cnt[i] <= (s2[i] == st[i] || take[i]) ? '0 : cnt[i] + 1'b1;
         pressed <= (pressed & ~clr) | rise;
         rv32_ready <= accept;
         if (accept)
            rv32_rdata <= write ? '0 : sel;
      end
endmodule

// File: tb/tb_rv32_input_reg.sv
// tb_rv32_input_reg: table-driven bus vectors plus timed sequences, checked by a
// scoreboard that pops an expected read value whenever the DUT acknowledges.
module tb_rv32_input_reg;
   localparam int D = 4;
   typedef struct {
      logic [3:0]  addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [31:0] exp;
      string       name;
   } vec_t;
   typedef struct {
      logic [31:0] exp;
      string       name;
   } sb_t;
   logic clk = 0, rst = 1, rv32_valid = 0, rv32_ready;
   logic [3:0] rv32_addr = 0, rv32_wstrb = 0;
   logic [31:0] rv32_wdata = 0, rv32_rdata;
   logic [15:0] sw_in = 0;
   logic [3:0] btn_in = 0;
   int errors = 0, checks = 0;
   sb_t sbq[$];
   vec_t rst_tab[4];
   vec_t reg_tab[8];

   rv32_input_reg #(.SWITCHES(16), .BUTTONS(4), .DEBOUNCE_CYCLES(D)) dut (
      .clk(clk), .rst(rst), .rv32_valid(rv32_valid), .rv32_ready(rv32_ready),
      .rv32_addr(rv32_addr), .rv32_wdata(rv32_wdata), .rv32_wstrb(rv32_wstrb),
      .rv32_rdata(rv32_rdata), .sw_in(sw_in), .btn_in(btn_in)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   always @(negedge clk)
      if (rv32_ready === 1'b1) begin
         sb_t e;
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ready: got rdata %h with no transaction pending", rv32_rdata);
         end else begin
            e = sbq.pop_front();
            check(e.name, rv32_rdata, e.exp);
         end
      end

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic xact(input logic [3:0] a, input logic [31:0] wd, input logic [3:0] ws,
                       input logic [31:0] exp, input string nm);
      int n = 0;
      sbq.push_back('{exp, nm});
      rv32_addr = a;
      rv32_wdata = wd;
      rv32_wstrb = ws;
      rv32_valid = 1;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (rv32_ready !== 1'b1 && n < 20);
      rv32_valid = 0;
      if (rv32_ready !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL %s: timeout, got no rv32_ready within 20 cycles", nm);
         void'(sbq.pop_back());
      end
   endtask

   task automatic run(input vec_t t);
      xact(t.addr, t.wdata, t.wstrb, t.exp, t.name);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst_tab[0] = '{4'h0, 32'h0, 4'h0, 32'h0, "rst_sw_state"};
      rst_tab[1] = '{4'h4, 32'h0, 4'h0, 32'h0, "rst_btn_state"};
      rst_tab[2] = '{4'h8, 32'h0, 4'h0, 32'h0, "rst_btn_pressed"};
      rst_tab[3] = '{4'hC, 32'h0, 4'h0, 32'h0, "rst_reserved"};
      reg_tab[0] = '{4'h4, 32'h0, 4'h0, 32'h0, "btn_state_released"};
      reg_tab[1] = '{4'h8, 32'h0, 4'h0, 32'h4, "pressed_after_release"};
      reg_tab[2] = '{4'h8, 32'h4, 4'b0010, 32'h0, "w1c_wrong_strobe_rdata"};
      reg_tab[3] = '{4'h9, 32'h0, 4'h0, 32'h4, "pressed_kept_low_addr_ignored"};
      reg_tab[4] = '{4'hC, 32'hFFFFFFFF, 4'hF, 32'h0, "reserved_write"};
      reg_tab[5] = '{4'hC, 32'h0, 4'h0, 32'h0, "reserved_read"};
      reg_tab[6] = '{4'h8, 32'h4, 4'b0001, 32'h0, "w1c_clear_rdata"};
      reg_tab[7] = '{4'h8, 32'h0, 4'h0, 32'h0, "pressed_cleared"};

      cycles(2);
      rst = 0;
      check("rst_ready", {31'b0, rv32_ready}, 32'h0);
      check("rst_rdata", rv32_rdata, 32'h0);
      foreach (rst_tab[i]) run(rst_tab[i]);

      // edge driven after E: read accepted at E+6 still sees the old level, E+7 sees the new
      sw_in[0] = 1;
      cycles(5);
      xact(4'h0, 32'h0, 4'h0, 32'h0, "sw0_not_before_full_count");
      sw_in[1] = 1;
      cycles(6);
      xact(4'h0, 32'h0, 4'h0, 32'h3, "sw1_at_full_count");

      sw_in[3] = 1;
      cycles(3);
      sw_in[3] = 0;
      cycles(10);
      xact(4'h0, 32'h0, 4'h0, 32'h3, "glitch_rejected");

      sw_in = 16'hA5A5;
      cycles(10);
      rv32_addr = 4'h0;
      rv32_wstrb = 4'h0;
      repeat (3) sbq.push_back('{32'h0000A5A5, "hs_rdata"});
      rv32_valid = 1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("hs_ready", {31'b0, rv32_ready}, 32'(i % 2));
      end
      rv32_valid = 0;
      cycles(1);
      xact(4'h0, 32'hFFFFFFFF, 4'hF, 32'h0, "write_sw_rdata");
      xact(4'h0, 32'h0, 4'h0, 32'h0000A5A5, "sw_after_write");

      btn_in = 4'b0100;
      cycles(7);
      xact(4'h4, 32'h0, 4'h0, 32'h4, "btn_state_held");
      cycles(2);
      btn_in = 4'b0000;
      cycles(10);
      foreach (reg_tab[i]) run(reg_tab[i]);

      btn_in[0] = 1;
      cycles(5);
      xact(4'h8, 32'h1, 4'b0001, 32'h0, "collision_w1c_rdata");
      xact(4'h8, 32'h0, 4'h0, 32'h1, "collision_set_wins");
      xact(4'h8, 32'h1, 4'b0001, 32'h0, "w1c_after_collision");
      xact(4'h8, 32'h0, 4'h0, 32'h0, "held_button_no_reset");
      btn_in = 4'b0000;

      xact(4'h0, 32'h0, 4'h0, 32'h0000A5A5, "sw_before_reset");
      sw_in = 16'hA5B5;
      cycles(4);
      rst = 1;
      rv32_valid = 1;
      rv32_addr = 4'h0;
      rv32_wstrb = 4'h0;
      cycles(1);
      rst = 0;
      rv32_valid = 0;
      check("rst_mid_ready", {31'b0, rv32_ready}, 32'h0);
      check("rst_mid_rdata", rv32_rdata, 32'h0);
      cycles(5);
      xact(4'h0, 32'h0, 4'h0, 32'h0, "sw_after_reset_early");
      xact(4'h0, 32'h0, 4'h0, 32'h0000A5B5, "sw_after_reset_settled");

      cycles(3);
      check("scoreboard_drained", 32'(sbq.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
